// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Read-side valid/ready bus of the UART receive FIFO.
//   master : the FIFO (drives head entry and rd_valid, samples rd_ready)
//   slave  : the host/bus consumer
//   Signals: rd_valid, rd_ready, rd_data[DATA_BITS], rd_parity_err, rd_frame_err
interface uart_rx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic                 rd_valid;
   logic                 rd_ready;
   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_parity_err;
   logic                 rd_frame_err;

   modport master (
      output rd_valid, rd_data, rd_parity_err, rd_frame_err,
      input  rd_ready
   );

   modport slave (
      input  rd_valid, rd_data, rd_parity_err, rd_frame_err,
      output rd_ready
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer sitting right after the UART receiver. Each rising edge of
//   rx_data_ready captures {frame_err, parity_err, data} into a DEPTH-entry
//   first-word-fall-through FIFO. The consumer drains it over rd_if.
//   Ports:
//     clk, reset_n        clock, async active-low reset
//     rx_data/_ready      character and strobe from the receiver (strobe spans many clk)
//     rx_parity_err       per-character parity error
//     rx_frame_err        per-character frame error
//     rd_if (master)      head entry + valid/ready handshake
//     count               occupancy 0..DEPTH
//     almost_full         count >= AF_LEVEL
//     overrun             sticky: a character was dropped while full
//     clr_overrun         pulse to clear overrun
module uart_rx_fifo #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16,
   parameter int AF_LEVEL  = 12
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [DATA_BITS-1:0]     rx_data,
   input  logic                     rx_data_ready,
   input  logic                     rx_parity_err,
   input  logic                     rx_frame_err,
   uart_rx_fifo_if.master           rd_if,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic                     overrun,
   input  logic                     clr_overrun
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = DATA_BITS + 2;

   if (DEPTH < 2 || (1 << PW) != DEPTH) begin : g_bad_depth
      $fatal(1, "uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $fatal(1, "uart_rx_fifo: AF_LEVEL must be in 1..DEPTH");
   end

   // Storage is intentionally not reset; only the pointers/count define validity.
   logic [EW-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          dr_q, dr_d;
   logic          overrun_q, overrun_d;
   logic          almost_full_q, almost_full_d;

   logic          push, pop, full, wr_en, drop, rd_valid;
   logic [EW-1:0] head;

   assign rd_valid = (count_q != '0);
   assign full     = (count_q == CW'(DEPTH));
   // Rising edge of the strobe; dr_q resets to 1 so a strobe already high at
   // reset release is ignored.
   assign push     = rx_data_ready & ~dr_q;
   assign pop      = rd_valid & rd_if.rd_ready;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign wr_en    = push & (~full | pop);
   assign drop     = push & full & ~pop;

   always_comb begin
      dr_d      = rx_data_ready;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);

      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Set wins over clear in the same cycle.
      if (drop)             overrun_d = 1'b1;
      else if (clr_overrun) overrun_d = 1'b0;

      almost_full_d = (count_d >= CW'(AF_LEVEL));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         dr_q          <= 1'b1;
         overrun_q     <= 1'b0;
         almost_full_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         dr_q          <= dr_d;
         overrun_q     <= overrun_d;
         almost_full_q <= almost_full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= {rx_frame_err, rx_parity_err, rx_data};
   end

   // Fall-through head; forced to zero while empty so outputs are clean after reset.
   assign head                = rd_valid ? mem[rd_ptr_q] : '0;
   assign rd_if.rd_valid      = rd_valid;
   assign rd_if.rd_data       = head[DATA_BITS-1:0];
   assign rd_if.rd_parity_err = head[DATA_BITS];
   assign rd_if.rd_frame_err  = head[DATA_BITS+1];

   assign count       = count_q;
   assign almost_full = almost_full_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Randomized bench for uart_rx_fifo with a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DW       = 8;
   localparam int DEPTH    = 16;
   localparam int AF_LEVEL = 12;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [DW-1:0] rx_data;
   logic          rx_data_ready;
   logic          rx_parity_err;
   logic          rx_frame_err;
   logic [4:0]    count;
   logic          almost_full;
   logic          overrun;
   logic          clr_overrun;

   uart_rx_fifo_if #(.DATA_BITS(DW)) rd_if ();

   uart_rx_fifo #(.DATA_BITS(DW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rx_data       (rx_data),
      .rx_data_ready (rx_data_ready),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err),
      .rd_if         (rd_if),
      .count         (count),
      .almost_full   (almost_full),
      .overrun       (overrun),
      .clr_overrun   (clr_overrun)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: entries are {frame, parity, data}.
   logic [9:0] mq[$];
   logic [9:0] popped[$];
   logic       m_prev_rdy;
   logic       m_ovr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_state();
      logic [9:0] h;
      h = (mq.size() != 0) ? mq[0] : 10'h0;
      chk("count",       32'(count), 32'(mq.size()));
      chk("rd_valid",    32'(rd_if.rd_valid), 32'(mq.size() != 0));
      chk("head",        {22'h0, rd_if.rd_frame_err, rd_if.rd_parity_err, rd_if.rd_data}, {22'h0, h});
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF_LEVEL));
      chk("overrun",     32'(overrun), 32'(m_ovr));
   endtask

   // One clock: model reacts to the inputs currently applied, then DUT is
   // sampled 1ns after the edge.
   task automatic step();
      logic m_push, m_pop;
      m_push     = rx_data_ready & ~m_prev_rdy;
      m_prev_rdy = rx_data_ready;
      m_pop      = (mq.size() != 0) && rd_if.rd_ready;
      if (m_pop) popped.push_back(mq.pop_front());
      if (m_push && mq.size() < DEPTH)
         mq.push_back({rx_frame_err, rx_parity_err, rx_data});
      @(posedge clk);
      #1;
      compare_state();
   endtask

   // Separate overrun bookkeeping kept simple: a push is dropped when the
   // buffer is full and nothing leaves in that cycle.
   task automatic step_ovr();
      logic m_push, m_pop, dropped;
      m_push     = rx_data_ready & ~m_prev_rdy;
      m_pop      = (mq.size() != 0) && rd_if.rd_ready;
      dropped    = m_push && (mq.size() == DEPTH) && !m_pop;
      if (dropped)          m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
      step();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      mq.delete();
      popped.delete();
      m_prev_rdy = 1'b1;
      m_ovr      = 1'b0;
      compare_state();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Strobe one character for hi clocks, then hold low for lo clocks.
   // rd_ready is random with probability rdy_pct percent each clock.
   task automatic strobe(input logic [DW-1:0] d, input logic pe, input logic fe,
                         input int hi, input int lo, input int rdy_pct);
      rx_data       = d;
      rx_parity_err = pe;
      rx_frame_err  = fe;
      rx_data_ready = 1'b1;
      for (int i = 0; i < hi; i++) begin
         rd_if.rd_ready = ($urandom_range(99) < rdy_pct);
         step_ovr();
      end
      rx_data_ready = 1'b0;
      rx_data       = DW'($urandom);
      rx_parity_err = 1'($urandom);
      rx_frame_err  = 1'($urandom);
      for (int i = 0; i < lo; i++) begin
         rd_if.rd_ready = ($urandom_range(99) < rdy_pct);
         step_ovr();
      end
   endtask

   task automatic drain();
      rd_if.rd_ready = 1'b1;
      for (int i = 0; i < 40 && mq.size() != 0; i++) step_ovr();
      rd_if.rd_ready = 1'b0;
      chk("drained", 32'(count), 32'd0);
   endtask

   logic [9:0] wrote[$];

   initial begin
      rx_data        = '0;
      rx_parity_err  = 1'b0;
      rx_frame_err   = 1'b0;
      rx_data_ready  = 1'b1;
      clr_overrun    = 1'b0;
      rd_if.rd_ready = 1'b0;
      m_prev_rdy     = 1'b1;
      m_ovr          = 1'b0;

      // 1: strobe held high across reset release must not push.
      do_reset();
      for (int i = 0; i < 20; i++) step_ovr();
      chk("t1_count", 32'(count), 32'd0);

      // 2: single long strobe, one entry, then pop.
      rx_data_ready = 1'b0;
      step_ovr(); step_ovr();
      rx_data = 8'hA5;
      rx_data_ready = 1'b1;
      step_ovr();
      chk("t2_valid_1clk", 32'(rd_if.rd_valid), 32'd1);
      for (int i = 0; i < 15; i++) step_ovr();
      chk("t2_count", 32'(count), 32'd1);
      chk("t2_data", 32'(rd_if.rd_data), 32'hA5);
      rx_data_ready = 1'b0;
      step_ovr();
      rd_if.rd_ready = 1'b1;
      step_ovr();
      rd_if.rd_ready = 1'b0;
      chk("t2_empty", 32'(rd_if.rd_valid), 32'd0);
      popped.delete();

      // 3: fill, overrun on 17th, drain in order, clear overrun.
      for (int i = 0; i < 16; i++) begin
         strobe(8'(i), 1'b0, 1'b0, 3, 2, 0);
         if (i == 10) chk("t3_af_below", 32'(almost_full), 32'd0);
         if (i == 11) chk("t3_af_at12",  32'(almost_full), 32'd1);
      end
      chk("t3_full", 32'(count), 32'd16);
      strobe(8'h10, 1'b0, 1'b0, 3, 2, 0);
      chk("t3_overrun", 32'(overrun), 32'd1);
      chk("t3_count", 32'(count), 32'd16);
      drain();
      chk("t3_npop", 32'(popped.size()), 32'd16);
      for (int i = 0; i < popped.size(); i++)
         chk("t3_order", 32'(popped[i][7:0]), 32'(i));
      clr_overrun = 1'b1;
      step_ovr();
      clr_overrun = 1'b0;
      chk("t3_clr", 32'(overrun), 32'd0);
      popped.delete();

      // 4: full buffer, push edge coincides with pop.
      for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i), 1'b0, 1'b0, 2, 1, 0);
      rx_data = 8'h5A;
      rx_data_ready = 1'b1;
      rd_if.rd_ready = 1'b1;
      step_ovr();
      rd_if.rd_ready = 1'b0;
      chk("t4_count", 32'(count), 32'd16);
      chk("t4_overrun", 32'(overrun), 32'd0);
      step_ovr(); step_ovr();
      rx_data_ready = 1'b0;
      step_ovr();
      drain();
      chk("t4_last", 32'(popped[popped.size()-1][7:0]), 32'h5A);
      popped.delete();

      // 5: error flags travel with their own character.
      strobe(8'h3C, 1'b1, 1'b0, 4, 2, 0);
      strobe(8'hC3, 1'b0, 1'b1, 4, 2, 0);
      chk("t5_first_pe", 32'(rd_if.rd_parity_err), 32'd1);
      chk("t5_first_fe", 32'(rd_if.rd_frame_err), 32'd0);
      drain();
      chk("t5_second", 32'(popped[1]), 32'h2C3);

      popped.delete();
      // 6: random stream of 40 characters, pointers wrap.
      for (int i = 0; i < 40; i++) begin
         logic [DW-1:0] d;
         logic pe, fe;
         d  = DW'($urandom);
         pe = 1'($urandom);
         fe = 1'($urandom);
         wrote.push_back({fe, pe, d});
         strobe(d, pe, fe, $urandom_range(1, 3), $urandom_range(1, 3), 60);
      end
      drain();
      chk("t6_npop", 32'(popped.size()), 32'(wrote.size()));
      for (int i = 0; i < wrote.size() && i < popped.size(); i++)
         chk("t6_order", 32'(popped[i]), 32'(wrote[i]));
      chk("t6_overrun", 32'(overrun), 32'd0);

      // Async reset mid-stream discards everything.
      strobe(8'h77, 1'b0, 1'b0, 2, 1, 0);
      do_reset();
      chk("rst_count", 32'(count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
